// File: rtl/peravg.sv
// Tempo-period measurer: counts tp_i pulses between button edges, reports raw
// periods and a running average over the last 2**AVG_LOG2 periods.
// Ports:
//   clk_i, rst_i (sync, active high), tp_i (time pulse), btn_i (debounced level)
//   per_o/per_valid_o   raw period and its update pulse
//   avg_o/avg_valid_o   average of a full history and its update pulse
//   fill_o              periods held in history, 0..2**AVG_LOG2
//   timeout_o           pulse when the period saturates and history is flushed
module peravg #(
    parameter int PER_MAX   = 11718,
    parameter int PER_W     = 14,
    parameter int AVG_LOG2  = 2,
    parameter int EDGE_MODE = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tp_i,
    input  logic               btn_i,
    output logic [PER_W-1:0]   per_o,
    output logic               per_valid_o,
    output logic [PER_W-1:0]   avg_o,
    output logic               avg_valid_o,
    output logic [AVG_LOG2:0]  fill_o,
    output logic               timeout_o
);

    localparam int D     = 1 << AVG_LOG2;
    localparam int SUM_W = PER_W + AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PER_W-1:0]  CNT_MAX   = PER_W'(PER_MAX);
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(D);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(D - 1);

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } state_e;

    state_e             state_q, state_d;
    logic               btn_q;
    logic [PER_W-1:0]   cnt_q, cnt_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic               per_valid_q, per_valid_d;
    logic [PER_W-1:0]   avg_q, avg_d;
    logic               avg_valid_q, avg_valid_d;
    logic [AVG_LOG2:0]  fill_q, fill_d;
    logic               timeout_q, timeout_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PER_W-1:0]   hist_q [D];
    logic [PER_W-1:0]   hist_d [D];

    logic               fall, rise, edge_det;
    logic               sat;
    logic               full;
    logic [PER_W-1:0]   oldest;
    logic [SUM_W-1:0]   sum_new;

    // Edge detection against the registered button level.
    always_comb begin
        fall = btn_q & ~btn_i;
        rise = ~btn_q & btn_i;
        if (EDGE_MODE == 0) begin
            edge_det = fall;
        end else if (EDGE_MODE == 1) begin
            edge_det = rise;
        end else begin
            edge_det = fall | rise;
        end
    end

    // Saturation wins over any edge in the same cycle.
    assign sat = (state_q == S_ARMED) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_d       = per_q;
        per_valid_d = 1'b0;
        timeout_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (edge_det) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (sat) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else if (edge_det) begin
                    // A tp_i coinciding with the edge belongs to neither period.
                    per_d       = cnt_q;
                    per_valid_d = 1'b1;
                    cnt_d       = '0;
                end else if (tp_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // History and running sum, updated the cycle after a capture.
    always_comb begin
        full    = (fill_q == FILL_FULL);
        oldest  = full ? hist_q[wptr_q] : '0;
        sum_new = sum_q + SUM_W'(per_q) - SUM_W'(oldest);

        hist_d      = hist_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;

        if (sat) begin
            fill_d = '0;
            sum_d  = '0;
            wptr_d = '0;
        end else if (per_valid_q) begin
            hist_d[wptr_q] = per_q;
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            fill_d = full ? fill_q : fill_q + 1'b1;
            sum_d  = sum_new;
            if (fill_d == FILL_FULL) begin
                avg_d       = PER_W'(sum_new >> AVG_LOG2);
                avg_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            btn_q       <= 1'b0;
            cnt_q       <= '0;
            per_q       <= '0;
            per_valid_q <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            fill_q      <= '0;
            timeout_q   <= 1'b0;
            sum_q       <= '0;
            wptr_q      <= '0;
            for (int i = 0; i < D; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_i;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            per_valid_q <= per_valid_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            fill_q      <= fill_d;
            timeout_q   <= timeout_d;
            sum_q       <= sum_d;
            wptr_q      <= wptr_d;
            hist_q      <= hist_d;
        end
    end

    assign per_o       = per_q;
    assign per_valid_o = per_valid_q;
    assign avg_o       = avg_q;
    assign avg_valid_o = avg_valid_q;
    assign fill_o      = fill_q;
    assign timeout_o   = timeout_q;

endmodule
